bin2rns_32_31_21_5: RTL and testbench

Forward converter for the {32,31,21,5} moduli set (M = 104160): takes a 17-bit binary integer and produces its four residues. It is the input-side counterpart of the RNS-to-binary back-end, and its x0..x3 outputs connect directly to that back-end's residue inputs. It reduces by end-around folding, using 2^5≡1 (mod 31), 2^6≡1 (mod 21) and 2^4≡1 (mod 5), with a fixed multi-cycle FSM and valid/ready handshakes on both sides.

---
 rtl/rns_32_31_21_5_pkg.sv | 24 ++
 rtl/eac_fold.sv | 24 ++
 rtl/bin2rns_32_31_21_5.sv | 140 ++++++++++++++
 tb/tb_bin2rns_32_31_21_5.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/rns_32_31_21_5_pkg.sv
// Shared constants and FSM encoding for the {32,31,21,5} RNS forward converter.
package rns_32_31_21_5_pkg;

    localparam int DYN_SIZE   = 17;
    localparam int MOD_1      = 32;
    localparam int MOD_2      = 31;
    localparam int MOD_3      = 21;
    localparam int MOD_4      = 5;
    localparam int MOD_1_K    = 5;
    localparam int MOD_SIZE_1 = 5;
    localparam int MOD_SIZE_2 = 5;
    localparam int MOD_SIZE_3 = 5;
    localparam int MOD_SIZE_4 = 3;
    localparam int M_PROD     = 104160;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FOLD1 = 3'd1,
        FOLD2 = 3'd2,
        CORR  = 3'd3,
        VALID = 3'd4
    } state_t;

endpackage

// File: rtl/eac_fold.sv
// End-around fold: sums the K-bit chunks of a W-bit word into an O-bit result.
module eac_fold #(
    parameter int K = 5,
    parameter int W = 17,
    parameter int O = 7
) (
    input  logic [W-1:0] i_a,
    output logic [O-1:0] o_sum
);

    localparam int NC = (W + K - 1) / K;
    localparam int PW = NC * K;

    logic [PW-1:0] w_pad;

    always_comb begin
        w_pad = PW'(i_a);
        o_sum = '0;
        for (int c = 0; c < NC; c++) begin
            o_sum = o_sum + O'(w_pad[c*K +: K]);
        end
    end

endmodule

// File: rtl/bin2rns_32_31_21_5.sv
// Binary-to-RNS forward converter for moduli {32,31,21,5}, fixed 4-cycle latency.
// Define BIN2RNS_RANGE_CHECK_EN to flag operands >= M_PROD on out_err.
module bin2rns_32_31_21_5
    import rns_32_31_21_5_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DYN_SIZE-1:0]   N,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [MOD_SIZE_1-1:0] x0,
    output logic [MOD_SIZE_2-1:0] x1,
    output logic [MOD_SIZE_3-1:0] x2,
    output logic [MOD_SIZE_4-1:0] x3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_err
);

    state_t                r_state;
    logic [DYN_SIZE-1:0]   r_n;
    logic [6:0]            r_m31;
    logic [7:0]            r_m21;
    logic [5:0]            r_m5;
    logic [MOD_SIZE_1-1:0] r_x0;
    logic [MOD_SIZE_2-1:0] r_x1;
    logic [MOD_SIZE_3-1:0] r_x2;
    logic [MOD_SIZE_4-1:0] r_x3;

    logic [6:0] w_f1_31;
    logic [7:0] w_f1_21;
    logic [5:0] w_f1_5;
    logic [5:0] w_f2_31;
    logic [6:0] w_f2_21;
    logic [4:0] w_f2_5;
    logic [4:0] w_c31;
    logic [4:0] w_c21;
    logic [2:0] w_c5;

    // First fold on the raw operand, second fold on the first-fold result.
    eac_fold #(.K(5), .W(DYN_SIZE), .O(7)) u_f1_31 (.i_a(r_n), .o_sum(w_f1_31));
    eac_fold #(.K(6), .W(DYN_SIZE), .O(8)) u_f1_21 (.i_a(r_n), .o_sum(w_f1_21));
    eac_fold #(.K(4), .W(DYN_SIZE), .O(6)) u_f1_5  (.i_a(r_n), .o_sum(w_f1_5));
    eac_fold #(.K(5), .W(7), .O(6)) u_f2_31 (.i_a(r_m31), .o_sum(w_f2_31));
    eac_fold #(.K(6), .W(8), .O(7)) u_f2_21 (.i_a(r_m21), .o_sum(w_f2_21));
    eac_fold #(.K(4), .W(6), .O(5)) u_f2_5  (.i_a(r_m5),  .o_sum(w_f2_5));

    always_comb begin
        w_c31 = r_m31[4:0];
        if (r_m31 >= 7'(MOD_2)) w_c31 = 5'(r_m31 - 7'(MOD_2));
    end

    always_comb begin
        w_c21 = r_m21[4:0];
        if (r_m21 >= 8'(3*MOD_3))      w_c21 = 5'(r_m21 - 8'(3*MOD_3));
        else if (r_m21 >= 8'(2*MOD_3)) w_c21 = 5'(r_m21 - 8'(2*MOD_3));
        else if (r_m21 >= 8'(MOD_3))   w_c21 = 5'(r_m21 - 8'(MOD_3));
    end

    always_comb begin
        w_c5 = r_m5[2:0];
        if (r_m5 >= 6'(3*MOD_4))      w_c5 = 3'(r_m5 - 6'(3*MOD_4));
        else if (r_m5 >= 6'(2*MOD_4)) w_c5 = 3'(r_m5 - 6'(2*MOD_4));
        else if (r_m5 >= 6'(MOD_4))   w_c5 = 3'(r_m5 - 6'(MOD_4));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_n     <= '0;
            r_m31   <= '0;
            r_m21   <= '0;
            r_m5    <= '0;
            r_x0    <= '0;
            r_x1    <= '0;
            r_x2    <= '0;
            r_x3    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_n     <= N;
                        r_state <= FOLD1;
                    end
                end
                FOLD1: begin
                    r_m31   <= w_f1_31;
                    r_m21   <= w_f1_21;
                    r_m5    <= w_f1_5;
                    r_state <= FOLD2;
                end
                FOLD2: begin
                    r_m31   <= {1'b0, w_f2_31};
                    r_m21   <= {1'b0, w_f2_21};
                    r_m5    <= {1'b0, w_f2_5};
                    r_state <= CORR;
                end
                CORR: begin
                    r_x0    <= r_n[MOD_1_K-1:0];
                    r_x1    <= w_c31;
                    r_x2    <= w_c21;
                    r_x3    <= w_c5;
                    r_state <= VALID;
                end
                VALID: begin
                    if (out_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef BIN2RNS_RANGE_CHECK_EN
    logic r_err_n;
    logic r_err;

    // Flag is taken with the operand and published with its residues.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_n <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == IDLE && in_valid) r_err_n <= (N >= DYN_SIZE'(M_PROD));
            if (r_state == CORR) r_err <= r_err_n;
        end
    end

    assign out_err = r_err;
`else
    assign out_err = 1'b0;
`endif

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == VALID);
    assign x0        = r_x0;
    assign x1        = r_x1;
    assign x2        = r_x2;
    assign x3        = r_x3;

endmodule

// File: tb/tb_bin2rns_32_31_21_5.sv
// Directed table-driven bench for bin2rns_32_31_21_5 plus backpressure and reset sequences.
module tb_bin2rns_32_31_21_5;

`ifdef BIN2RNS_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    typedef struct {
        logic [16:0] n;
        int          e0;
        int          e1;
        int          e2;
        int          e3;
        bit          err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [16:0] N;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  x0;
    logic [4:0]  x1;
    logic [4:0]  x2;
    logic [2:0]  x3;
    logic        out_valid;
    logic        out_ready;
    logic        out_err;

    int errors = 0;
    int checks = 0;
    int lat;
    vec_t vecs[6];

    bin2rns_32_31_21_5 dut (
        .clk       (clk),
        .reset     (reset),
        .N         (N),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x0        (x0),
        .x1        (x1),
        .x2        (x2),
        .x3        (x3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge where out_valid is seen (or budget ends).
    task automatic convert(input logic [16:0] n, output int l);
        N        = n;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        l = 1;
        while (!out_valid && l < 20) begin
            @(negedge clk);
            l++;
        end
    endtask

    task automatic chk_res(input string tag, input int e0, input int e1,
                           input int e2, input int e3, input bit er);
        chk({tag, ".x0"}, 32'(x0), e0);
        chk({tag, ".x1"}, 32'(x1), e1);
        chk({tag, ".x2"}, 32'(x2), e2);
        chk({tag, ".x3"}, 32'(x3), e3);
        chk({tag, ".err"}, 32'(out_err), 32'(er));
    endtask

    initial begin
        vecs[0] = '{n: 17'd0,      e0: 0,  e1: 0,  e2: 0,  e3: 0, err: 1'b0};
        vecs[1] = '{n: 17'd12345,  e0: 25, e1: 7,  e2: 18, e3: 0, err: 1'b0};
        vecs[2] = '{n: 17'd104159, e0: 31, e1: 30, e2: 20, e3: 4, err: 1'b0};
        vecs[3] = '{n: 17'd131071, e0: 31, e1: 3,  e2: 10, e3: 1, err: RC};
        vecs[4] = '{n: 17'd104160, e0: 0,  e1: 0,  e2: 0,  e3: 0, err: RC};
        vecs[5] = '{n: 17'd65535,  e0: 31, e1: 1,  e2: 15, e3: 0, err: 1'b0};

        reset     = 1'b0;
        N         = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.out_valid", 32'(out_valid), 0);
        chk_res("rst", 0, 0, 0, 0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst.in_ready", 32'(in_ready), 1);

        for (int i = 0; i < 6; i++) begin
            chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 1);
            convert(vecs[i].n, lat);
            chk($sformatf("v%0d.latency", i), 32'(lat), 4);
            chk_res($sformatf("v%0d", i), vecs[i].e0, vecs[i].e1,
                    vecs[i].e2, vecs[i].e3, vecs[i].err);
            @(negedge clk);
        end

        // Backpressure: hold VALID three cycles, stray in_valid must be ignored
        out_ready = 1'b0;
        convert(17'd12345, lat);
        chk("bp.latency", 32'(lat), 4);
        N        = 17'd999;
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("bp%0d.out_valid", c), 32'(out_valid), 1);
            chk($sformatf("bp%0d.in_ready", c), 32'(in_ready), 0);
            chk_res($sformatf("bp%0d", c), 25, 7, 18, 0, 1'b0);
        end
        out_ready = 1'b1;
        N         = 17'd31;
        in_valid  = 1'b1;
        @(negedge clk);
        chk("bp.idle.out_valid", 32'(out_valid), 0);
        chk("bp.idle.in_ready", 32'(in_ready), 1);
        chk("bp.idle.hold.x0", 32'(x0), 25);
        convert(17'd31, lat);
        chk("b2b.latency", 32'(lat), 4);
        chk_res("b2b", 31, 0, 10, 1, 1'b0);
        @(negedge clk);

        // Reset while in FOLD2 discards the operand and clears outputs at once
        N        = 17'd12345;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mrst.out_valid", 32'(out_valid), 0);
        chk_res("mrst", 0, 0, 0, 0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst.in_ready", 32'(in_ready), 1);
        convert(17'd100, lat);
        chk("post.latency", 32'(lat), 4);
        chk_res("post", 4, 7, 16, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
